// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared FSM state type, tick divider and silence word helpers for audio_word_feeder
package audio_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } feeder_state_t;

    // Number of clock cycles between word launches.
    function automatic int tick_div(input int system_frequency, input int sampling_frequency);
        return system_frequency / sampling_frequency;
    endfunction

    // Mid-scale word {1'b1, zeros}, returned at 64 bits; callers keep the low width bits.
    function automatic logic [63:0] silence_word(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - power-of-two word buffer with push/pop, full/empty and occupancy count
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("word_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A push while full or a pop while empty is silently dropped.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/audio_word_feeder.sv
// rtl/audio_word_feeder.sv - buffers sample words and launches one per sample tick into a serializer; optional AUDIO_FEEDER_UNDERRUN_CNT_EN adds underrun_cnt_o
module audio_word_feeder
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH        = 16,
    parameter int FIFO_DEPTH         = 8,
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int SAMPLING_FREQUENCY = 1000000
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          wr_valid_i,
    input  logic [WORD_LENGTH-1:0]        wr_data_i,
    output logic                          wr_ready_o,
    output logic                          ser_enable_o,
    output logic [WORD_LENGTH-1:0]        ser_data_o,
    input  logic                          ser_done_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          underrun_o,
    output logic                          late_o
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                    underrun_cnt_o
`endif
);

    localparam int TICK_DIV = tick_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
    localparam int TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [63:0] SILENCE_FULL = silence_word(WORD_LENGTH);
    localparam logic [WORD_LENGTH-1:0] SILENCE = SILENCE_FULL[WORD_LENGTH-1:0];

    // The serializer needs at least a word plus handshake cycles between ticks.
    generate
        if (TICK_DIV < WORD_LENGTH + 2) begin : g_bad_tick_div
            $error("audio_word_feeder: TICK_DIV must be at least WORD_LENGTH+2");
        end
    endgenerate

    feeder_state_t           state;
    logic [TW-1:0]           tick_cnt;
    logic                    tick;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [WORD_LENGTH-1:0]  fifo_head;

    assign tick       = (tick_cnt == TICK_LAST);
    assign wr_ready_o = !fifo_full;
    assign fifo_push  = wr_valid_i && wr_ready_o;
    assign fifo_pop   = (state == ST_IDLE) && tick && !fifo_empty;

    word_fifo #(
        .WIDTH (WORD_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock_i),
        .rst_n     (reset_n_i),
        .push      (fifo_push),
        .push_data (wr_data_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_o)
    );

    // Free-running sample tick divider.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Launch FSM: a tick in IDLE always starts a word (silence on underrun); a tick in SEND is only flagged.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= ST_IDLE;
            ser_enable_o <= 1'b0;
            ser_data_o   <= '0;
            underrun_o   <= 1'b0;
            late_o       <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            late_o     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        if (fifo_empty) begin
                            ser_data_o <= SILENCE;
                            underrun_o <= 1'b1;
                        end else begin
                            ser_data_o <= fifo_head;
                        end
                        state        <= ST_SEND;
                        ser_enable_o <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tick) begin
                        late_o <= 1'b1;
                    end
                    // A done coinciding with a tick still finishes; that tick is lost.
                    if (ser_done_i) begin
                        state        <= ST_IDLE;
                        ser_enable_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    ser_enable_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            underrun_cnt_o <= 8'd0;
        end else if (underrun_o && underrun_cnt_o != 8'hFF) begin
            underrun_cnt_o <= underrun_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_word_feeder.sv
// tb/tb_audio_word_feeder.sv - self-checking bench for audio_word_feeder with queue-based reference model
module tb_audio_word_feeder;

    localparam int W        = 16;
    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        ser_enable;
    logic [15:0] ser_data;
    logic        ser_done;
    logic [3:0]  fifo_count;
    logic        underrun;
    logic        late;
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    always #5 clock = ~clock;

    audio_word_feeder #(
        .WORD_LENGTH        (W),
        .FIFO_DEPTH         (DEPTH),
        .SYSTEM_FREQUENCY   (100000000),
        .SAMPLING_FREQUENCY (1000000)
    ) dut (
        .clock_i      (clock),
        .reset_n_i    (reset_n),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .ser_enable_o (ser_enable),
        .ser_data_o   (ser_data),
        .ser_done_i   (ser_done),
        .fifo_count_o (fifo_count),
        .underrun_o   (underrun),
        .late_o       (late)
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (underrun_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a word queue, a phase counter and a busy flag.
    logic [15:0] q[$];
    int          phase;
    bit          busy;
    logic [15:0] m_data;
    bit          m_und;
    bit          m_late;

    typedef struct {
        bit          valid;
        logic [15:0] data;
        int          exp_count;
        bit          exp_ready;
    } push_vec_t;

    push_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase  = 0;
        busy   = 0;
        m_data = 16'h0000;
        m_und  = 0;
        m_late = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit dn);
        bit tick;
        bit ready;
        tick   = (phase == TICK_DIV - 1);
        ready  = (q.size() < DEPTH);
        m_und  = 0;
        m_late = 0;
        if (tick && !busy) begin
            if (q.size() > 0) begin
                m_data = q.pop_front();
            end else begin
                m_data = 16'h8000;
                m_und  = 1;
            end
            busy = 1;
        end else begin
            if (tick) m_late = 1;
            if (busy && dn) busy = 0;
        end
        if (v && ready) q.push_back(d);
        phase = (phase + 1) % TICK_DIV;
    endtask

    task automatic check_model();
        bit ok;
        ok = (ser_enable === busy) && (ser_data === m_data) && (underrun === m_und) &&
             (late === m_late) && (fifo_count === 4'(q.size())) && (wr_ready === (q.size() < DEPTH));
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL model t=%0t: got en=%b data=%h und=%b late=%b cnt=%0d rdy=%b expected en=%b data=%h und=%b late=%b cnt=%0d rdy=%b",
                     $time, ser_enable, ser_data, underrun, late, fifo_count, wr_ready,
                     busy, m_data, m_und, m_late, q.size(), (q.size() < DEPTH));
        end
    endtask

    task automatic cycle(input bit v, input logic [15:0] d, input bit dn);
        wr_valid = v;
        wr_data  = d;
        ser_done = dn;
        @(posedge clock);
        #1;
        model_step(v, d, dn);
        check_model();
    endtask

    task automatic do_reset(input bit chk);
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        ser_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if (chk) begin
            check("reset_enable", 32'(ser_enable), 32'd0);
            check("reset_data", 32'(ser_data), 32'h0);
            check("reset_underrun", 32'(underrun), 32'd0);
            check("reset_late", 32'(late), 32'd0);
            check("reset_count", 32'(fifo_count), 32'd0);
            check("reset_ready", 32'(wr_ready), 32'd1);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_enable();
        for (int i = 0; i < 2 * TICK_DIV + 10 && !ser_enable; i++) cycle(0, 16'h0, 0);
        check("wait_enable_timeout", 32'(ser_enable), 32'd1);
    endtask

    task automatic finish_send(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 0);
        cycle(0, 16'h0, 1);
    endtask

    initial begin
        int late_n;
        bit en_ok;
        bit cnt_ok;
        int age;
        int target;
        int rate;
        bit v;
        bit dn;

        for (int i = 0; i < 9; i++) begin
            vecs[i].valid     = 1;
            vecs[i].data      = 16'h1000 + 16'(i);
            vecs[i].exp_count = (i < 8) ? i + 1 : 8;
            vecs[i].exp_ready = (i < 7);
        end
        vecs[9].valid     = 0;
        vecs[9].data      = 16'hFFFF;
        vecs[9].exp_count = 8;
        vecs[9].exp_ready = 0;

        // Reset state, then first tick on an empty FIFO.
        do_reset(1);
        for (int i = 0; i < TICK_DIV - 1; i++) cycle(0, 16'h0, 0);
        check("no_enable_before_tick", 32'(ser_enable), 32'd0);
        cycle(0, 16'h0, 0);
        check("underrun_enable", 32'(ser_enable), 32'd1);
        check("underrun_pulse", 32'(underrun), 32'd1);
        check("silence_word", 32'(ser_data), 32'h8000);
        cycle(0, 16'h0, 0);
        check("underrun_one_cycle", 32'(underrun), 32'd0);
        finish_send(15);
        check("enable_drops_after_done", 32'(ser_enable), 32'd0);

        // Two words in order.
        do_reset(0);
        cycle(1, 16'h1234, 0);
        cycle(1, 16'hABCD, 0);
        check("two_words_count", 32'(fifo_count), 32'd2);
        wait_enable();
        check("first_word", 32'(ser_data), 32'h1234);
        check("count_after_first", 32'(fifo_count), 32'd1);
        finish_send(16);
        check("idle_after_first", 32'(ser_enable), 32'd0);
        wait_enable();
        check("second_word", 32'(ser_data), 32'hABCD);
        check("count_after_second", 32'(fifo_count), 32'd0);
        finish_send(16);

        // Fill past full from the vector table, then drain in order.
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].valid, vecs[i].data, 0);
            check($sformatf("fill_count_%0d", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("fill_ready_%0d", i), 32'(wr_ready), 32'(vecs[i].exp_ready));
        end
        for (int k = 0; k < 8; k++) begin
            wait_enable();
            check($sformatf("drain_word_%0d", k), 32'(ser_data), 32'h1000 + 32'(k));
            finish_send(16);
        end
        check("drained_count", 32'(fifo_count), 32'd0);

        // Done withheld past the next tick.
        do_reset(0);
        cycle(1, 16'h0A0A, 0);
        cycle(1, 16'h0B0B, 0);
        wait_enable();
        check("late_setup_word", 32'(ser_data), 32'h0A0A);
        late_n = 0;
        en_ok  = 1;
        cnt_ok = 1;
        for (int i = 0; i < 120; i++) begin
            cycle(0, 16'h0, 0);
            late_n += int'(late);
            if (!ser_enable) en_ok = 0;
            if (fifo_count != 4'd1) cnt_ok = 0;
        end
        check("late_pulse_count", 32'(late_n), 32'd1);
        check("late_enable_held", 32'(en_ok), 32'd1);
        check("late_no_pop", 32'(cnt_ok), 32'd1);
        check("late_data_held", 32'(ser_data), 32'h0A0A);
        cycle(0, 16'h0, 1);
        check("late_done_idle", 32'(ser_enable), 32'd0);
        wait_enable();
        check("late_next_word", 32'(ser_data), 32'h0B0B);

        // Tick and done in the same SEND cycle.
        cycle(1, 16'h0C0C, 0);
        for (int i = 0; i < TICK_DIV && phase != TICK_DIV - 1; i++) cycle(0, 16'h0, 0);
        cycle(0, 16'h0, 1);
        check("tick_done_late", 32'(late), 32'd1);
        check("tick_done_idle", 32'(ser_enable), 32'd0);
        check("tick_done_no_pop", 32'(fifo_count), 32'd1);
        wait_enable();
        check("tick_done_next_word", 32'(ser_data), 32'h0C0C);

        // Asynchronous reset in the middle of SEND.
        cycle(1, 16'h0D0D, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_enable", 32'(ser_enable), 32'd0);
        check("async_reset_count", 32'(fifo_count), 32'd0);
        check("async_reset_ready", 32'(wr_ready), 32'd1);
        do_reset(0);

        // Randomized traffic with a reactive serializer.
        age    = 0;
        target = 20;
        for (int i = 0; i < 4500; i++) begin
            rate = (i < 1500) ? 2 : ((i < 3000) ? 30 : 1);
            v    = ($urandom_range(0, 99) < rate);
            if (busy) begin
                age++;
                dn = (age >= target);
            end else begin
                age    = 0;
                target = $urandom_range(5, 170);
                dn     = ($urandom_range(0, 39) == 0);
            end
            cycle(v, 16'($urandom), dn);
        end

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
        do_reset(0);
        check("underrun_cnt_reset", 32'(underrun_cnt), 32'd0);
        for (int t = 0; t < 300; t++) begin
            wait_enable();
            finish_send(16);
        end
        check("underrun_cnt_saturated", 32'(underrun_cnt), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_word_feeder.md
AUDIO_WORD_FEEDER -- requirements
Module: audio_word_feeder

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, sample word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, word buffer depth; power of two, at least 2.
REQ-003 SHALL have parameter SYSTEM_FREQUENCY, default 100000000, clock_i frequency in Hz.
REQ-004 SHALL have parameter SAMPLING_FREQUENCY, default 1000000, word launch rate in Hz.
REQ-005 SHALL have port clock_i, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wr_valid_i, input, 1 bit: producer offers wr_data_i.
REQ-008 SHALL have port wr_data_i, input, WORD_LENGTH bits: sample word to buffer.
REQ-009 SHALL have port wr_ready_o, output, 1 bit: FIFO not full.
REQ-010 SHALL have port ser_enable_o, output, 1 bit: enable to the downstream serializer.
REQ-011 SHALL have port ser_data_o, output, WORD_LENGTH bits: word presented to the serializer.
REQ-012 SHALL have port ser_done_i, input, 1 bit: one-cycle pulse from the serializer, last bit sent.
REQ-013 SHALL have port fifo_count_o, output, $clog2(FIFO_DEPTH)+1 bits: occupancy.
REQ-014 SHALL have port underrun_o, output, 1 bit: one-cycle pulse, tick found the FIFO empty.
REQ-015 SHALL have port late_o, output, 1 bit: one-cycle pulse, tick arrived while still in SEND.

Function
REQ-016 SHALL define TICK_DIV = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY; tick counter runs 0..TICK_DIV-1, wraps, tick asserted when count = TICK_DIV-1.
REQ-017 SHALL push wr_data_i when wr_valid_i && wr_ready_o; a word pushed in cycle N becomes poppable in cycle N+1.
REQ-018 SHALL use a two-state FSM: IDLE and SEND.
REQ-019 SHALL, on tick in IDLE with count > 0, pop the head into ser_data_o, go to SEND and assert ser_enable_o from the next cycle.
REQ-020 SHALL, on tick in IDLE with count = 0, load ser_data_o with the silence word {1'b1, zeros} (mid-scale, 0x8000 at 16 bits), pulse underrun_o, and still enter SEND.
REQ-021 SHALL, in SEND, hold ser_enable_o = 1 and ser_data_o stable until ser_done_i = 1, then return to IDLE with ser_enable_o = 0 from the next cycle.
REQ-022 SHALL, on tick while in SEND, ignore the tick for launching, pulse late_o, pop nothing and stay in SEND.
REQ-023 SHALL, on tick and ser_done_i in the same SEND cycle, treat it as the late case: return to IDLE and launch at the next tick.
REQ-024 SHALL, on simultaneous push and pop, leave fifo_count_o unchanged; a push while full is never accepted.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-026 SHALL fail elaboration if TICK_DIV < WORD_LENGTH+2.

Reset
REQ-027 SHALL, while reset_n_i = 0, force FSM = IDLE, tick counter = 0, FIFO empty (pointers 0, fifo_count_o = 0), ser_enable_o = 0, ser_data_o = 0, underrun_o = 0, late_o = 0, wr_ready_o = 1.
REQ-028 SHALL, on reset asserted mid-SEND, drop ser_enable_o immediately (asynchronously) and discard buffered words.

Configuration
REQ-029 SHALL, with macro AUDIO_FEEDER_UNDERRUN_CNT_EN defined, add output underrun_cnt_o, 8 bits, saturating at 255, incremented per underrun_o pulse and cleared by reset.
REQ-030 SHALL, without AUDIO_FEEDER_UNDERRUN_CNT_EN, omit the port and the counter entirely.

Structure
REQ-031 SHALL place the FSM state enum, the silence-word function and the TICK_DIV computation in shared package audio_pkg.
REQ-032 SHALL implement the buffer as sub-module word_fifo (parameterised width and depth, push/pop, full/empty, count).

Verification
REQ-033 Reset release, FIFO empty, no writes -> first tick at cycle 99 pulses underrun_o, ser_data_o = 0x8000, ser_enable_o high from cycle 100.
REQ-034 Push 0x1234, 0xABCD; done pulsed 16 cycles after each enable -> ser_data_o = 0x1234 at the first tick, 0xABCD at the next, fifo_count_o goes 2 -> 1 -> 0.
REQ-035 Push 9 words with FIFO_DEPTH = 8 and no ticks -> wr_ready_o low after 8 pushes, 9th word not accepted, fifo_count_o = 8.
REQ-036 ser_done_i withheld past the next tick -> late_o pulse, no pop, ser_enable_o stays high until done arrives.
REQ-037 Assert reset_n_i low mid-SEND -> ser_enable_o = 0 in the same cycle, fifo_count_o = 0, wr_ready_o = 1.
REQ-038 With AUDIO_FEEDER_UNDERRUN_CNT_EN, run 300 empty ticks -> underrun_cnt_o = 255.
